// File: rtl/apb_defines.sv
// Shared APB definitions: slave FSM encoding, master slave count, wait-counter width
// and a small address-decode helper.
package apb_defines;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam int TOTAL_SLAVE = 4;
  localparam int WAIT_W      = 4;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word register array: one write port, one combinational read port and a tap of
// register 0 for use as a live control word.
module apb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] reg0
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[widx] <= wdata;
    end
  end

  assign rdata = r_mem[ridx];
  assign reg0  = r_mem[0];

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave register bank with a fixed number of wait states per access.
// Setup latches index, direction and error; completion happens once the wait count drains.
module apb_slave_regs
  import apb_defines::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] reg0_q
);

  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [WAIT_W-1:0]     WAIT_INIT = WAIT_W'(WAIT_STATES);

  apb_state_e            r_state, w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt, w_wait_cnt_nxt;
  logic [RIDX_W-1:0]     r_idx, w_idx_nxt;
  logic                  r_write, w_write_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_addr_err;
  logic                  w_ready;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Full-width range compare so an index beyond the register count is caught before truncation.
  assign w_addr_err = addr_misaligned(paddr[1:0]) ||
                      ({3'b000, paddr[ADDR_WIDTH-1:2]} >= REG_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_write    <= w_write_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_idx_nxt      = r_idx;
    w_write_nxt    = r_write;
    w_err_nxt      = r_err;
    case (r_state)
      ST_IDLE: begin
        if (psel && !penable) begin
          w_state_nxt    = ST_ACCESS;
          w_wait_cnt_nxt = WAIT_INIT;
          w_idx_nxt      = paddr[RIDX_W+1:2];
          w_write_nxt    = pwrite;
          w_err_nxt      = w_addr_err;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Losing psel aborts the transfer, even mid-count.
        if (!psel) begin
          w_state_nxt    = ST_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt != '0) begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end else if (penable) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_ready = (r_state == ST_ACCESS) && (r_wait_cnt == '0);
    w_we    = w_ready && psel && penable && r_write && !r_err;
    pready  = w_ready;
    pslverr = w_ready && r_err;
    if (w_ready && !r_write && !r_err) begin
      prdata = w_rdata;
    end else begin
      prdata = '0;
    end
  end

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (RIDX_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .widx  (r_idx),
    .wdata (pwdata),
    .ridx  (r_idx),
    .rdata (w_rdata),
    .reg0  (reg0_q)
  );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: three instances (0, 2 and 3 wait states) on a shared bus,
// checked against an array model of the register contents.
module tb_apb_slave_regs;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_a [3];
  logic        pready_a [3];
  logic        pslverr_a[3];
  logic [31:0] reg0_a   [3];

  int          wsv[3] = '{0, 2, 3};
  logic [31:0] model[3][NR];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  apb_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NR), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]),
    .reg0_q(reg0_a[0]));
  apb_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NR), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]),
    .reg0_q(reg0_a[1]));
  apb_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(NR), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .rst(rst), .psel(psel[2]), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_a[2]), .pready(pready_a[2]), .pslverr(pslverr_a[2]),
    .reg0_q(reg0_a[2]));

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < NR; r++) model[d][r] = 32'h0;
  endtask

  task automatic idle(input int n);
    psel = 3'b000; penable = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // One transfer on instance d; returns right after the completion edge with the bus released.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int waits);
    bit ok;
    psel = 3'b000; psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = 8'($urandom);
    waits = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pready_a[d] === 1'b1) begin ok = 1'b1; break; end
      tests++;
      if (prdata_a[d] !== 32'h0 || pslverr_a[d] !== 1'b0) begin
        fails++;
        $display("FAIL wait_outputs dut%0d: prdata=%h pslverr=%b, required 0/0", d, prdata_a[d], pslverr_a[d]);
      end
      waits++;
      @(posedge clk); #1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL pready_timeout dut%0d: no pready within 40 cycles", d);
    end
    rd = prdata_a[d]; er = pslverr_a[d];
    @(posedge clk); #1;
    psel = 3'b000; penable = 1'b0;
  endtask

  task automatic check_xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] rd, exp_rd;
    bit er, exp_er;
    int waits, idx;
    idx    = int'(a) / 4;
    exp_er = (a % 4 != 0) || (idx >= NR);
    exp_rd = (wr || exp_er) ? 32'h0 : model[d][idx];
    xfer(d, wr, a, wd, rd, er, waits);
    if (wr && !exp_er) model[d][idx] = wd;
    tests++;
    if (waits != wsv[d]) begin
      fails++;
      $display("FAIL wait_count dut%0d addr=%h: got %0d, required %0d", d, a, waits, wsv[d]);
    end
    tests++;
    if (er !== exp_er) begin
      fails++;
      $display("FAIL pslverr dut%0d addr=%h wr=%0d: got %b, required %b", d, a, wr, er, exp_er);
    end
    tests++;
    if (rd !== exp_rd) begin
      fails++;
      $display("FAIL prdata dut%0d addr=%h wr=%0d: got %h, required %h", d, a, wr, rd, exp_rd);
    end
    tests++;
    if (reg0_a[d] !== model[d][0]) begin
      fails++;
      $display("FAIL reg0_q dut%0d: got %h, required %h", d, reg0_a[d], model[d][0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0;
    clear_model();
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (pready_a[d] !== 1'b0 || pslverr_a[d] !== 1'b0 || prdata_a[d] !== 32'h0 || reg0_a[d] !== 32'h0) begin
        fails++;
        $display("FAIL reset dut%0d: pready=%b pslverr=%b prdata=%h reg0=%h, required all 0",
                 d, pready_a[d], pslverr_a[d], prdata_a[d], reg0_a[d]);
      end
    end
  endtask

  task automatic test_basic();
    check_xfer(0, 1'b1, 8'h04, 32'hDEADBEEF);
    idle(1);
    check_xfer(0, 1'b0, 8'h04, 32'h0);
  endtask

  task automatic test_wait_states();
    idle(1);
    check_xfer(2, 1'b1, 8'h00, 32'h12345678);
    tests++;
    if (reg0_a[2] !== 32'h12345678) begin
      fails++;
      $display("FAIL reg0_after_write: got %h, required 12345678", reg0_a[2]);
    end
  endtask

  task automatic test_errors();
    idle(1);
    check_xfer(0, 1'b1, 8'h40, 32'hCAFEF00D);
    check_xfer(0, 1'b1, 8'h06, 32'hBADC0DE5);
    check_xfer(0, 1'b0, 8'h40, 32'h0);
    check_xfer(0, 1'b0, 8'h06, 32'h0);
    for (int r = 0; r < NR; r++) check_xfer(0, 1'b0, 8'(r * 4), 32'h0);
  endtask

  task automatic test_back_to_back();
    idle(2);
    check_xfer(0, 1'b1, 8'h08, 32'h000000A5);
    check_xfer(0, 1'b0, 8'h08, 32'h0);
    check_xfer(1, 1'b1, 8'h10, 32'h5A5A0001);
    check_xfer(1, 1'b0, 8'h10, 32'h0);
  endtask

  task automatic test_abort();
    idle(1);
    check_xfer(1, 1'b1, 8'h0C, 32'h00000011);
    idle(1);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hBAD0BAD0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    psel = 3'b000; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (pready_a[1] !== 1'b0 || pslverr_a[1] !== 1'b0) begin
        fails++;
        $display("FAIL abort_pready: pready=%b pslverr=%b, required 0/0", pready_a[1], pslverr_a[1]);
      end
      @(posedge clk); #1;
    end
    check_xfer(1, 1'b0, 8'h0C, 32'h0);
  endtask

  task automatic test_idle_penable();
    idle(1);
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (pready_a[0] !== 1'b0) begin
        fails++;
        $display("FAIL idle_penable_pready: got %b, required 0", pready_a[0]);
      end
    end
    idle(1);
    check_xfer(0, 1'b0, 8'h14, 32'h0);
  endtask

  task automatic test_reset_mid();
    idle(1);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0000FFFF;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    clear_model();
    #1;
    tests++;
    if (reg0_a[2] !== 32'h0 || pready_a[2] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: reg0=%h pready=%b, required 0/0", reg0_a[2], pready_a[2]);
    end
    psel = 3'b000; penable = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    idle(1);
    check_xfer(2, 1'b0, 8'h00, 32'h0);
    check_xfer(2, 1'b1, 8'h00, 32'h00C0FFEE);
    check_xfer(2, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_random();
    logic [7:0] a;
    int d, sel;
    for (int n = 0; n < 80; n++) begin
      d   = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      a = 8'($urandom_range(0, NR - 1) * 4);
      else if (sel < 9) a = 8'($urandom_range(NR * 4, 255)) & 8'hFC;
      else              a = 8'($urandom) | 8'h01;
      check_xfer(d, 1'($urandom), a, $urandom);
      idle(int'($urandom_range(0, 2)));
    end
    for (int dd = 0; dd < 3; dd++)
      for (int r = 0; r < NR; r++) check_xfer(dd, 1'b0, 8'(r * 4), 32'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort();
    test_idle_penable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_slave_regs.md
# apb_slave_regs

APB slave register bank driven by the APB master interface stage: it consumes one `psel` bit, `penable`, `pwrite`, `paddr` and `pwdata`, and returns `prdata`, `pready` and `pslverr`. It holds `NUM_REGS` word-wide read/write registers and inserts a programmable number of wait states per access. It is the first concrete slave on the bus and serves as the bring-up target for the master.

## Interface

- `DATA_WIDTH`, 32, register and bus data width.
- `ADDR_WIDTH`, 8, `paddr` width; byte address.
- `NUM_REGS`, 16, number of registers; must satisfy `NUM_REGS*4 <= 2**ADDR_WIDTH`.
- `WAIT_STATES`, 0, wait cycles per access, range 0..15.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `psel` in 1: this slave's select bit from the master's `psel` vector.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_WIDTH: byte address.
- `pwdata` in DATA_WIDTH: write data.
- `prdata` out DATA_WIDTH: read data, valid while `pready`=1 on a read.
- `pready` out 1: transfer-complete strobe.
- `pslverr` out 1: error flag, valid only while `pready`=1.
- `reg0_q` out DATA_WIDTH: live value of register 0, used as a control word.

## Operation

- FSM states:
  - IDLE: `psel`=1 and `penable`=0 (setup) → ACCESS. Latch index `paddr[ADDR_WIDTH-1:2]`, latch `pwrite`, load `wait_cnt` with `WAIT_STATES`, and compute `err`.
  - ACCESS: while `wait_cnt` != 0, decrement it; `pready`=0.
  - ACCESS with `wait_cnt` == 0: `pready`=1. If `psel` and `penable` are both 1, complete the transfer → IDLE.
- `err` = (`paddr[1:0]` != 0) or (index >= `NUM_REGS`).
- Write completion with `err`=0: `reg[index]` <= `pwdata`.
- Write completion with `err`=1: no register changes.
- Read: `prdata` = `reg[index]` when `err`=0, else 0. `prdata` is 0 whenever `pready`=0.
- `pslverr` = `err` during the completion cycle, else 0.
- All flags and outputs are derived from registered state, never combinationally from bus inputs.

## Timing

- Reset values: state IDLE, `wait_cnt` 0, all registers 0, `prdata` 0, `pready` 0, `pslverr` 0, `reg0_q` 0.
- Transfer length is 2 + `WAIT_STATES` cycles from setup to completion. With `WAIT_STATES`=0, `pready`=1 in the first access cycle.
- A written value is visible on `reg0_q` and to reads on the cycle after the completion edge.
- Back-to-back transfers: a setup in the cycle immediately after completion is accepted with no idle gap.
- `penable`=1 while in IDLE (protocol violation): ignored; no state change and no write.
- `psel` falls while in ACCESS: abort → IDLE. No write occurs, and `pready` and `pslverr` stay 0.
- Read-after-write to the same register returns the new value.
- `rst` asserted mid-transfer: immediate return to reset values. No partial write survives.
- Any `paddr` change during ACCESS is ignored; the index latched at setup is used.

## Structure

- Shared package or defines file `apb_defines` holds:
  - the FSM state encoding (IDLE/ACCESS);
  - the `total_slave` count used by the master;
  - the default `WAIT_STATES` width of 4 bits.
- Sub-module `apb_regfile`: `NUM_REGS` × `DATA_WIDTH` flops with asynchronous reset. It has one write port (`we`, `widx`, `wdata`), one combinational read port (`ridx`, `rdata`) and a `reg0` tap. The FSM, wait counter and error decode live in `apb_slave_regs`.

## Test plan

- Reset, then write 0xDEADBEEF to 0x04 and read 0x04, `WAIT_STATES`=0 → each transfer completes in 2 cycles; read returns 0xDEADBEEF; `pslverr`=0.
- `WAIT_STATES`=3: write 0x12345678 to 0x00 → `pready` low for 3 access cycles, then high on the 4th; `reg0_q`=0x12345678 on the next cycle.
- Write to 0x40 (index 16) and to 0x06 (misaligned) → `pslverr`=1 with `pready`; all registers unchanged; reads of those addresses return 0 with `pslverr`=1.
- Back-to-back: write 0xA5 to 0x08, then read 0x08 with setup immediately following completion → read returns 0xA5 with no idle cycle.
- `psel` dropped in the 2nd access cycle of a write with `WAIT_STATES`=2 → no `pready`; a later read of that address returns the old value.
- `rst` pulsed during the access phase of a write of 0xFFFF to 0x00 → `reg0_q`=0, `pready`=0, FSM back in IDLE, and the next transfer works normally.
